// File: rtl/morse_capture_adapt_pkg.sv
// Shared definitions for the Morse capture block: default sizes, FSM state
// encodings and the dit-unit multipliers used for timing thresholds.
package morse_capture_adapt_pkg;

  localparam int CNT_W_DEF     = 16;
  localparam int MAX_LEN_DEF   = 6;

  localparam int DAH_MULT      = 2;
  localparam int CHAR_GAP_MULT = 2;
  localparam int WORD_GAP_MULT = 5;
  localparam int LONG_MULT     = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MARK    = 2'd1,
    ST_SPACE   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

endpackage

// File: rtl/morse_capture_adapt_counter.sv
// Saturating pulse-length counter: clears to 0 on reset, restarts at 1 on load1,
// otherwise counts up on each enabled cycle and holds at all-ones.
module morse_capture_adapt_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load1,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      if (load1)
        count <= {{(W-1){1'b0}}, 1'b1};
      else if (count != '1)
        count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/morse_capture_adapt.sv
// Morse keying capture: times marks/spaces, assembles dit/dah characters and
// word gaps into records behind a one-entry ready/valid buffer.
// Optional dit-unit adaptation is enabled by defining MORSE_CAPTURE_ADAPT_EN.
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_IDLE    | between words, waiting for the first mark
//   ST_MARK    | key down, timing the current element
//   ST_SPACE   | key up, waiting for next element, char gap or word gap
//   ST_LOCKOUT | mark exceeded the long limit, waiting for key release
module morse_capture_adapt
  import morse_capture_adapt_pkg::*;
#(
  parameter  int CNT_W   = CNT_W_DEF,
  parameter  int MAX_LEN = MAX_LEN_DEF,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic               ce,
  input  logic               signal,
  input  logic [CNT_W-1:0]   dit_time_init,
  input  logic [CNT_W-1:0]   tol_time,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LEN_W-1:0]   out_len,
  output logic [MAX_LEN-1:0] out_bits,
  output logic               out_error,
  output logic               out_word_end,
  output logic [CNT_W-1:0]   cur_dit_time,
  output logic               overrun
);

  localparam int TW = CNT_W + 3;

  state_t             state, state_nxt;
  logic               last_signal;
  logic [CNT_W-1:0]   count;
  logic [LEN_W-1:0]   len, len_nxt;
  logic [MAX_LEN-1:0] bits, bits_nxt;
  logic               err, err_nxt;
  logic               char_act, char_act_nxt;
  logic               emit, emit_word;
  logic               rise, fall, full, is_dah, long_hit;
  logic [TW-1:0]      d_ext, cnt_ext, thr_dah, thr_char, thr_word, thr_long;

  assign rise = signal & ~last_signal;
  assign fall = ~signal & last_signal;

  morse_capture_adapt_counter #(.W(CNT_W)) u_counter (
    .clk   (clk),
    .rst   (aclr),
    .en    (ce),
    .load1 (signal != last_signal),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (aclr)
      last_signal <= 1'b0;
    else if (ce)
      last_signal <= signal;
  end

  // Widened arithmetic so 7*D + tol cannot wrap.
  assign d_ext    = TW'(cur_dit_time);
  assign cnt_ext  = TW'(count);
  assign thr_dah  = d_ext * TW'(DAH_MULT);
  assign thr_char = d_ext * TW'(CHAR_GAP_MULT);
  assign thr_word = d_ext * TW'(WORD_GAP_MULT);
  assign thr_long = d_ext * TW'(LONG_MULT) + TW'(tol_time);

  assign is_dah   = cnt_ext > thr_dah;
  assign long_hit = cnt_ext > thr_long;
  assign full     = (len == LEN_W'(MAX_LEN));

  always_ff @(posedge clk) begin
    if (aclr) begin
      state    <= ST_IDLE;
      len      <= '0;
      bits     <= '0;
      err      <= 1'b0;
      char_act <= 1'b0;
    end else begin
      state    <= state_nxt;
      len      <= len_nxt;
      bits     <= bits_nxt;
      err      <= err_nxt;
      char_act <= char_act_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    len_nxt      = len;
    bits_nxt     = bits;
    err_nxt      = err;
    char_act_nxt = char_act;
    emit         = 1'b0;
    emit_word    = 1'b0;
    if (ce) begin
      unique case (state)
        ST_IDLE: begin
          if (rise) begin
            state_nxt    = ST_MARK;
            len_nxt      = '0;
            bits_nxt     = '0;
            err_nxt      = 1'b0;
            char_act_nxt = 1'b1;
          end
        end
        ST_MARK: begin
          // An over-long mark is flagged even if it ends on this very cycle.
          if (long_hit) begin
            err_nxt   = 1'b1;
            state_nxt = fall ? ST_SPACE : ST_LOCKOUT;
          end else if (fall) begin
            state_nxt = ST_SPACE;
            if (full) begin
              err_nxt = 1'b1;
            end else begin
              bits_nxt = {bits[MAX_LEN-2:0], is_dah};
              len_nxt  = len + LEN_W'(1);
            end
          end
        end
        ST_LOCKOUT: begin
          if (fall)
            state_nxt = ST_SPACE;
        end
        ST_SPACE: begin
          if (rise) begin
            state_nxt    = ST_MARK;
            char_act_nxt = 1'b1;
          end else if (char_act && (cnt_ext >= thr_char)) begin
            emit         = 1'b1;
            char_act_nxt = 1'b0;
            len_nxt      = '0;
            bits_nxt     = '0;
            err_nxt      = 1'b0;
          end else if (!char_act && (cnt_ext >= thr_word)) begin
            emit      = 1'b1;
            emit_word = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      out_valid    <= 1'b0;
      out_len      <= '0;
      out_bits     <= '0;
      out_error    <= 1'b0;
      out_word_end <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (emit && (!out_valid || out_ready)) begin
        out_valid    <= 1'b1;
        out_len      <= emit_word ? '0 : len;
        out_bits     <= emit_word ? '0 : bits;
        out_error    <= emit_word ? 1'b0 : err;
        out_word_end <= emit_word;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (emit && out_valid && !out_ready)
        overrun <= 1'b1;
    end
  end

`ifdef MORSE_CAPTURE_ADAPT_EN
  logic [CNT_W-1:0] dit_q;
  logic [TW-1:0]    dit_adj;
  logic             adapt_hit;

  assign adapt_hit = ce && (state == ST_MARK) && fall && !long_hit && !is_dah && !full && !err;
  assign dit_adj   = TW'(dit_q) - TW'(dit_q >> 2) + TW'(count >> 2);

  always_ff @(posedge clk) begin
    if (aclr) begin
      dit_q <= dit_time_init;
    end else if (ce && (state == ST_IDLE)) begin
      dit_q <= dit_time_init;
    end else if (adapt_hit) begin
      if (dit_adj == '0)
        dit_q <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (dit_adj > TW'({CNT_W{1'b1}}))
        dit_q <= '1;
      else
        dit_q <= dit_adj[CNT_W-1:0];
    end
  end

  assign cur_dit_time = dit_q;
`else
  assign cur_dit_time = dit_time_init;
`endif

endmodule

// File: doc/morse_capture_adapt.md
MORSE_CAPTURE_ADAPT -- requirements
Module: morse_capture_adapt

Interface
REQ-001 CNT_W, 16, width of pulse counter and all timing values.
REQ-002 MAX_LEN, 6, maximum dit/dah elements per character.
REQ-003 LEN_W, $clog2(MAX_LEN+1), width of length output (derived, not overridden).
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 aclr  in  1  reset, synchronous, active-high.
REQ-006 ce  in  1  clock enable; all state advances only when ce=1, except output handshake.
REQ-007 signal  in  1  keyed Morse input, 1=mark.
REQ-008 dit_time_init  in  CNT_W  dit unit D, loaded at reset and while idle.
REQ-009 tol_time  in  CNT_W  tolerance added to the long-mark limit.
REQ-010 out_valid  out  1  record available.
REQ-011 out_ready  in  1  consumer accepts record when out_valid & out_ready.
REQ-012 out_len  out  LEN_W  element count of record.
REQ-013 out_bits  out  MAX_LEN  elements, LSB = last element, 1=dah.
REQ-014 out_error  out  1  record malformed.
REQ-015 out_word_end  out  1  record is a word-gap marker.
REQ-016 cur_dit_time  out  CNT_W  current dit unit D.
REQ-017 overrun  out  1  sticky: a record was dropped.

Function
REQ-018 States IDLE, MARK, SPACE, LOCKOUT; transitions evaluated on ce cycles using registered last_signal.
REQ-019 Pulse counter: 1 on the cycle signal differs from last_signal, else +1 per ce, saturating at all-ones.
REQ-020 Thresholds use CNT_W+3-bit arithmetic: dah split 2D, char gap 2D, word gap 5D, long mark 7D+tol_time.
REQ-021 IDLE->MARK on 0->1; clears len, bits, error.
REQ-022 MARK->SPACE on 1->0: count > 2D appends 1, else appends 0; len increments.
REQ-023 Append with len==MAX_LEN: error=1, len and bits unchanged.
REQ-024 MARK with count > 7D+tol_time: error=1, go LOCKOUT; LOCKOUT->SPACE on 1->0 with no append.
REQ-025 SPACE->MARK on 0->1 before char gap; the element continues the current character.
REQ-026 SPACE count reaching 2D: emit character record (word_end=0); character state clears.
REQ-027 SPACE count reaching 5D after a character: emit record len=0, bits=0, error=0, word_end=1; go IDLE.
REQ-028 Emission: record registered into a one-entry output buffer; out_valid rises the cycle after the threshold cycle.
REQ-029 out_valid held with stable fields until handshake; cleared the cycle after out_valid & out_ready unless a new record loads that same edge.
REQ-030 Emission while buffer full and not draining same cycle: record dropped, overrun=1 until reset.
REQ-031 Handshake is not gated by ce.

Reset
REQ-032 aclr=1: state IDLE, out_valid=0, out_len=0, out_bits=0, out_error=0, out_word_end=0, overrun=0, counter=0, last_signal=0, D=dit_time_init; aclr overrides ce and any in-progress character or buffered record, which is discarded.

Configuration
REQ-033 Macro MORSE_CAPTURE_ADAPT_EN: defined -> on each appended dit without error, D <= D - (D>>2) + (count>>2), never below 1.
REQ-034 Undefined: D follows dit_time_init in every state; cur_dit_time = dit_time_init.

Structure
REQ-035 Shared defines include holds default CNT_W, MAX_LEN, state encodings and threshold multipliers (2, 5, 7).
REQ-036 Pulse counting reuses existing COUNTER sub-module with sync clear value 1; no other sub-modules.

Verification
REQ-037 D=10, tol=2, out_ready=1, macro off: mark 10, space 10, mark 30, space 60 -> record len=2 bits=01 error=0, then word_end record.
REQ-038 7 dits spaced 10, MAX_LEN=6 -> record len=6 bits=000000 error=1.
REQ-039 Mark 80 cycles (limit 72) -> error record len=0 after release and 20-cycle space.
REQ-040 out_ready=0, two characters emitted -> first held stable, second dropped, overrun=1.
REQ-041 Macro on, D init 10, six dits of 14 -> cur_dit_time ratchets upward monotonically toward 14.
REQ-042 aclr asserted mid-MARK with out_valid=1 -> next cycle all outputs at reset values, state IDLE.
